// File: rtl/and_gate_checker.sv
// Response monitor for and_gate: accepts (A,B) vectors, waits SETTLE cycles,
// compares the DUT output against A&B and keeps per-run pass/fail statistics.
module and_gate_checker #(
    parameter int NUM_VEC = 4,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             vld_i,
    input  logic             A_i,
    input  logic             B_i,
    input  logic             F_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] idx_o,
    output logic [CNT_W-1:0] first_fail_idx_o,
    output logic [1:0]       first_fail_ab_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VEC,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int                SET_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    NUM_VEC_W = (CNT_W+1)'(NUM_VEC);
    localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE - 1);

    state_t           state_q;
    logic             ready_q, busy_q, done_q, err_q;
    logic             a_q, b_q;
    logic [SET_W-1:0] set_cnt_q;
    logic [CNT_W-1:0] pass_q, fail_q, idx_q, ffi_q;
    logic [1:0]       ffab_q;

    // Saturating next values; counters stick at all-ones rather than wrap.
    logic [CNT_W-1:0] pass_d, fail_d, idx_d;
    logic             match;

    always_comb begin
        pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
        fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
        idx_d  = (idx_q  == CNT_MAX) ? idx_q  : idx_q  + CNT_W'(1);
        match  = (F_i == (a_q & b_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            set_cnt_q <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            idx_q     <= '0;
            ffi_q     <= '0;
            ffab_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_WAIT_VEC;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        pass_q  <= '0;
                        fail_q  <= '0;
                        idx_q   <= '0;
                        ffi_q   <= '0;
                        ffab_q  <= '0;
                    end
                end
                S_WAIT_VEC: begin
                    if (vld_i && ready_q) begin
                        a_q       <= A_i;
                        b_q       <= B_i;
                        set_cnt_q <= SET_LOAD;
                        ready_q   <= 1'b0;
                        state_q   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (set_cnt_q == '0) state_q   <= S_CHECK;
                    else                 set_cnt_q <= set_cnt_q - SET_W'(1);
                end
                S_CHECK: begin
                    if (match) begin
                        pass_q <= pass_d;
                    end else begin
                        fail_q <= fail_d;
                        err_q  <= 1'b1;
                        // Only the first mismatch of a run is recorded.
                        if (!err_q) begin
                            ffi_q  <= idx_q;
                            ffab_q <= {a_q, b_q};
                        end
                    end
                    idx_q <= idx_d;
                    if ({1'b0, idx_d} == NUM_VEC_W) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_WAIT_VEC;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o          = ready_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign pass_cnt_o       = pass_q;
    assign fail_cnt_o       = fail_q;
    assign idx_o            = idx_q;
    assign first_fail_idx_o = ffi_q;
    assign first_fail_ab_o  = ffab_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Randomized self-checking bench for and_gate_checker; two configurations
// (NUM_VEC=4/SETTLE=1/CNT_W=8 and NUM_VEC=3/SETTLE=3/CNT_W=2) vs. a run-level model.
module tb_and_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst[2], start[2], vld[2], a[2], b[2], f[2];
    logic rdy[2], bsy[2], dn[2], er[2];
    logic [7:0] pc[2], fc[2], ix[2], ffi[2];
    logic [1:0] ffab[2];

    logic       rdy0, bsy0, dn0, er0, rdy1, bsy1, dn1, er1;
    logic [7:0] pc0, fc0, ix0, ffi0;
    logic [1:0] ffab0, pc1, fc1, ix1, ffi1, ffab1;

    and_gate_checker #(.NUM_VEC(4), .SETTLE(1), .CNT_W(8)) u0 (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .vld_i(vld[0]),
        .A_i(a[0]), .B_i(b[0]), .F_i(f[0]),
        .ready_o(rdy0), .busy_o(bsy0), .done_o(dn0), .err_o(er0),
        .pass_cnt_o(pc0), .fail_cnt_o(fc0), .idx_o(ix0),
        .first_fail_idx_o(ffi0), .first_fail_ab_o(ffab0)
    );

    and_gate_checker #(.NUM_VEC(3), .SETTLE(3), .CNT_W(2)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .vld_i(vld[1]),
        .A_i(a[1]), .B_i(b[1]), .F_i(f[1]),
        .ready_o(rdy1), .busy_o(bsy1), .done_o(dn1), .err_o(er1),
        .pass_cnt_o(pc1), .fail_cnt_o(fc1), .idx_o(ix1),
        .first_fail_idx_o(ffi1), .first_fail_ab_o(ffab1)
    );

    assign rdy[0] = rdy0;  assign rdy[1] = rdy1;
    assign bsy[0] = bsy0;  assign bsy[1] = bsy1;
    assign dn[0]  = dn0;   assign dn[1]  = dn1;
    assign er[0]  = er0;   assign er[1]  = er1;
    assign pc[0]  = pc0;   assign pc[1]  = 8'(pc1);
    assign fc[0]  = fc0;   assign fc[1]  = 8'(fc1);
    assign ix[0]  = ix0;   assign ix[1]  = 8'(ix1);
    assign ffi[0] = ffi0;  assign ffi[1] = 8'(ffi1);
    assign ffab[0] = ffab0; assign ffab[1] = ffab1;

    int nvec[2]   = '{4, 3};
    int settle[2] = '{1, 3};
    int cmax[2]   = '{255, 3};

    // Run-level reference: what the checker should report so far this run.
    int m_pass[2], m_fail[2], m_idx[2], m_ffi[2], m_ffab[2], m_err[2];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear(input int i);
        m_pass[i] = 0; m_fail[i] = 0; m_idx[i] = 0;
        m_ffi[i]  = 0; m_ffab[i] = 0; m_err[i] = 0;
    endtask

    task automatic chk_all(input int i, input string tag);
        bit fin;
        fin = (m_idx[i] == nvec[i]);
        chk({tag, "_pass"},  32'(pc[i]),   m_pass[i]);
        chk({tag, "_fail"},  32'(fc[i]),   m_fail[i]);
        chk({tag, "_idx"},   32'(ix[i]),   m_idx[i]);
        chk({tag, "_err"},   32'(er[i]),   m_err[i]);
        chk({tag, "_ffi"},   32'(ffi[i]),  m_ffi[i]);
        chk({tag, "_ffab"},  32'(ffab[i]), m_ffab[i]);
        chk({tag, "_done"},  32'(dn[i]),   32'(fin));
        chk({tag, "_ready"}, 32'(rdy[i]),  32'(!fin));
        chk({tag, "_busy"},  32'(bsy[i]),  32'(!fin));
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_ready"}, 32'(rdy[i]), 0);
        chk({tag, "_busy"},  32'(bsy[i]), 0);
        chk({tag, "_done"},  32'(dn[i]),  0);
        chk({tag, "_err"},   32'(er[i]),  0);
        chk({tag, "_cnts"},  32'({pc[i], fc[i], ix[i], ffi[i]}), 0);
        chk({tag, "_ffab"},  32'(ffab[i]), 0);
    endtask

    task automatic do_reset(input int i);
        @(negedge clk); rst[i] = 1'b1;
        @(negedge clk); @(negedge clk); rst[i] = 1'b0;
        model_clear(i);
        chk_idle(i, "reset");
        // vld while idle must be dropped
        vld[i] = 1'b1; a[i] = 1'b1; b[i] = 1'b1;
        @(negedge clk); vld[i] = 1'b0;
        @(negedge clk);
        chk_idle(i, "idle_vld");
    endtask

    task automatic do_start(input int i);
        @(negedge clk); start[i] = 1'b1;
        @(negedge clk); start[i] = 1'b0;
        model_clear(i);
        chk_all(i, "start");
    endtask

    // Present one vector; F is held for the whole check window while A/B wander.
    task automatic do_vec(input int i, input bit av, input bit bv, input bit fv, input bit abort);
        int n = 0;
        int idx0;
        while (!rdy[i] && n < 50) begin @(negedge clk); n++; end
        if (!rdy[i]) begin
            chk("ready_timeout", 32'(rdy[i]), 1);
            return;
        end
        a[i] = av; b[i] = bv; f[i] = fv; vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
        if (abort) begin
            rst[i] = 1'b1;
            @(negedge clk); rst[i] = 1'b0;
            model_clear(i);
            chk_idle(i, "midrun_rst");
            return;
        end
        idx0 = m_idx[i];
        for (int s = 0; s <= settle[i]; s++) begin
            chk("lat_ready", 32'(rdy[i]), 0);
            chk("lat_idx",   32'(ix[i]),  idx0);
            a[i]     = 1'($urandom);
            b[i]     = 1'($urandom);
            vld[i]   = 1'($urandom);
            start[i] = 1'($urandom);
            @(negedge clk);
        end
        vld[i] = 1'b0; start[i] = 1'b0;
        if (fv == (av & bv)) begin
            m_pass[i] = (m_pass[i] < cmax[i]) ? m_pass[i] + 1 : m_pass[i];
        end else begin
            if (m_err[i] == 0) begin
                m_ffi[i]  = m_idx[i];
                m_ffab[i] = {30'd0, av, bv};
            end
            m_fail[i] = (m_fail[i] < cmax[i]) ? m_fail[i] + 1 : m_fail[i];
            m_err[i]  = 1;
        end
        m_idx[i] = (m_idx[i] < cmax[i]) ? m_idx[i] + 1 : m_idx[i];
        chk_all(i, "vec");
    endtask

    task automatic rand_run(input int i);
        bit av, bv, flip;
        do_start(i);
        for (int v = 0; v < nvec[i]; v++) begin
            av   = 1'($urandom);
            bv   = 1'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            do_vec(i, av, bv, (av & bv) ^ flip, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; vld[i] = 1'b0;
            a[i] = 1'b0; b[i] = 1'b0; f[i] = 1'b0;
        end

        // Configuration 0: NUM_VEC=4, SETTLE=1
        do_reset(0);
        do_start(0);
        do_vec(0, 0, 0, 0, 0); do_vec(0, 1, 0, 0, 0);
        do_vec(0, 0, 1, 0, 0); do_vec(0, 1, 1, 1, 0);
        chk("run0_pass", 32'(pc[0]), 4);

        do_start(0);
        do_vec(0, 0, 0, 0, 0); do_vec(0, 1, 0, 1, 0);
        do_vec(0, 0, 1, 0, 0); do_vec(0, 1, 1, 0, 0);
        chk("run1_ffab", 32'(ffab[0]), 2);

        do_start(0);  // clears a run that ended with err=1
        do_vec(0, 1, 1, 1, 0); do_vec(0, 0, 1, 0, 0);
        do_vec(0, 1, 0, 0, 0); do_vec(0, 0, 0, 0, 0);

        do_start(0);
        do_vec(0, 1, 1, 1, 0); do_vec(0, 0, 1, 0, 0);
        do_vec(0, 1, 0, 0, 1);  // reset during SETTLE of vector index 2
        do_start(0);
        for (int v = 0; v < 4; v++) do_vec(0, v[1], v[0], v[1] & v[0], 0);

        for (int r = 0; r < 10; r++) rand_run(0);

        // Configuration 1: NUM_VEC=3, SETTLE=3, CNT_W=2
        do_reset(1);
        do_start(1);
        do_vec(1, 1, 1, 1, 0); do_vec(1, 0, 1, 0, 0); do_vec(1, 1, 0, 0, 0);
        do_start(1);
        do_vec(1, 1, 1, 0, 0); do_vec(1, 0, 1, 1, 0); do_vec(1, 0, 0, 1, 0);
        chk("sat_fail", 32'(fc[1]), 3);
        for (int r = 0; r < 8; r++) rand_run(1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
